exe_stage_mc: RTL and testbench
===============================

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

Interface
REQ-001 Parameter DATA_W, default 32, sets the datapath width (legal values 8..64).
REQ-002 Parameter REG_AW, default 4, sets the destination register index width.
REQ-003 Ports, listed as name  direction  width  meaning; clock and reset come first.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept.
- exe_cmd  in  4  operation.
- wb_en, mem_r_en, mem_w_en  in  1 each  control flags passed through.
- dest  in  REG_AW  destination index passed through.
- pc_in  in  DATA_W  branch base.
- imm24  in  24  signed branch offset in words.
- val_rn, val_rm  in  DATA_W  register-file operands.
- val2  in  DATA_W  pre-shifted operand 2.
- op2_sel  in  1  1 selects val2, 0 selects forwarded Rm.
- sel_src1, sel_src2  in  2 each  forwarding selects: 00 regfile, 01 mem_val, 10 wb_val, 11 regfile.
- mem_val, wb_val  in  DATA_W  forwarded values.
- c_in  in  1  carry flag.
- out_valid  out  1  output register full.
- out_ready  in  1  downstream accepts.
- alu_result, br_addr, val_rm_out  out  DATA_W  registered results.
- status  out  4  registered {N,Z,C,V}.
- dest_out, wb_en_out, mem_r_en_out, mem_w_en_out  out  registered pass-through.
- busy  out  1  multiply in progress.

Function
REQ-004 A request SHALL be accepted when in_valid and in_ready are both 1 on a rising edge; forwarding muxes and all inputs SHALL be sampled only in that cycle.
REQ-005 in_ready SHALL be 1 only when the FSM is in IDLE and either out_valid is 0 or out_ready is 1.
REQ-006 exe_cmd encodings SHALL be:
- 0001 MOV, 1001 MVN
- 0010 ADD, 0011 ADC
- 0100 SUB, 0101 SBC
- 0110 AND, 0111 ORR, 1000 EOR
- 1010 MUL
- any other code yields a result of 0.
REQ-007 For all non-MUL commands, the output register SHALL load one cycle after acceptance (latency 1) and out_valid SHALL assert.
REQ-008 ADD, ADC, SUB and SBC SHALL compute in DATA_W+1 bits, with the following flags:
- C is the carry out; for SUB/SBC, C is the ARM not-borrow.
- V is the signed overflow.
- SBC is rn - op2 - !c_in.
REQ-009 For logic, MOV, MVN, MUL and undefined commands, N and Z SHALL be computed from the result, C SHALL equal the accepted c_in, and V SHALL be 0.
REQ-010 br_addr SHALL equal pc_in + (sign-extended imm24 << 2), truncated to DATA_W bits.
REQ-011 val_rm_out SHALL carry the forwarded Rm value, independent of op2_sel.
REQ-012 The FSM SHALL have states IDLE, MUL and DONE:
- IDLE to MUL on acceptance of command 1010.
- MUL to DONE after exactly DATA_W shift-add iterations, counted by an internal counter.
- DONE to IDLE when the output register loads, which requires out_valid=0 or out_ready=1; the FSM waits in DONE otherwise.
REQ-013 The MUL result SHALL be the low DATA_W bits of the unsigned product; busy SHALL be 1 in MUL and DONE.
REQ-014 The output register SHALL hold its contents while out_valid=1 and out_ready=0, and SHALL clear out_valid when out_ready=1 and no new result loads.
REQ-015 Full throughput SHALL be achieved: back-to-back non-MUL requests with out_ready held at 1 SHALL produce one result per cycle.

Reset
REQ-016 Assertion of rst SHALL act immediately and asynchronously, including in the middle of a multiply, which is discarded.
REQ-017 During reset, the FSM SHALL be IDLE and the multiply counter SHALL be 0.
REQ-018 During reset, out_valid, busy, all registered data outputs, status, dest_out and all enable outputs SHALL be 0.
REQ-019 in_ready SHALL become 1 in the first cycle after rst deasserts.

Configuration
REQ-020 With macro EXE_MUL_EN defined, MUL SHALL behave per REQ-012 and REQ-013.
REQ-021 Without EXE_MUL_EN, the MUL state and counter SHALL be absent, command 1010 SHALL be treated as undefined (result 0, latency 1), and busy SHALL be tied to 0.

Verification
REQ-022 The bench SHALL cover the following scenarios at DATA_W=32:
- Issue ADD 0x7FFFFFFF + 1 with out_ready=1 -> one cycle later alu_result=0x80000000, status=1001.
- Issue SUB 5 - 5 with sel_src1=01 and mem_val=5 -> alu_result=0, status=0110.
- Issue MUL 0x1234 x 0x10 with EXE_MUL_EN defined -> busy for 32 cycles, then alu_result=0x12340 and out_valid=1 with latency 33.
- Hold out_ready=0 with out_valid=1 and present a second request -> in_ready=0 and the output stays stable until out_ready=1.
- Assert rst mid-MUL -> all outputs 0 immediately, and in_ready=1 the cycle after release.
- Apply pc_in=0x100 and imm24=0xFFFFFF -> br_addr=0x0FC.

Source files
------------

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with operand forwarding, ALU, branch-target adder
// and a registered valid/ready output. Optional 1-bit-per-cycle shift-add
// multiplier is compiled in when EXE_MUL_EN is defined.
module exe_stage_mc #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [REG_AW-1:0] dest,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [23:0]       imm24,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val2,
    input  logic              op2_sel,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [DATA_W-1:0] wb_val,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] br_addr,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        status,
    output logic [REG_AW-1:0] dest_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              busy
);
    localparam int MSB = DATA_W - 1;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [DATA_W-1:0] src1, rm_fwd, op2;
    logic [DATA_W-1:0] alu_res, br_calc;
    logic [DATA_W:0]   sum_w;
    logic              alu_c, alu_v, is_arith, is_sub;
    logic [3:0]        alu_status;
    logic [63:0]       br_off;
    logic              out_valid_reg, out_free, accept, load_out;

    logic [DATA_W-1:0] ld_result, ld_br, ld_rm;
    logic [3:0]        ld_status;
    logic [REG_AW-1:0] ld_dest;
    logic [2:0]        ld_flags;

    logic [DATA_W-1:0] alu_result_reg, br_addr_reg, val_rm_out_reg;
    logic [3:0]        status_reg;
    logic [REG_AW-1:0] dest_out_reg;
    logic [2:0]        flags_out_reg;

    assign out_free = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Forwarding muxes for Rn and Rm (code 11 falls back to the register file)
    always_comb begin
        src1   = val_rn;
        rm_fwd = val_rm;
        case (sel_src1)
            2'b01:   src1 = mem_val;
            2'b10:   src1 = wb_val;
            default: src1 = val_rn;
        endcase
        case (sel_src2)
            2'b01:   rm_fwd = mem_val;
            2'b10:   rm_fwd = wb_val;
            default: rm_fwd = val_rm;
        endcase
    end

    assign op2 = op2_sel ? val2 : rm_fwd;

    // ALU: arithmetic in DATA_W+1 bits so the top bit is the carry / not-borrow
    always_comb begin
        alu_res  = '0;
        sum_w    = '0;
        is_arith = 1'b0;
        is_sub   = 1'b0;
        alu_c    = c_in;
        alu_v    = 1'b0;
        case (exe_cmd)
            CMD_MOV: alu_res = op2;
            CMD_MVN: alu_res = ~op2;
            CMD_ADD: begin
                is_arith = 1'b1;
                sum_w    = {1'b0, src1} + {1'b0, op2};
            end
            CMD_ADC: begin
                is_arith = 1'b1;
                sum_w    = {1'b0, src1} + {1'b0, op2} + {{DATA_W{1'b0}}, c_in};
            end
            CMD_SUB: begin
                is_arith = 1'b1;
                is_sub   = 1'b1;
                sum_w    = {1'b0, src1} + {1'b0, ~op2} + {{DATA_W{1'b0}}, 1'b1};
            end
            CMD_SBC: begin
                is_arith = 1'b1;
                is_sub   = 1'b1;
                sum_w    = {1'b0, src1} + {1'b0, ~op2} + {{DATA_W{1'b0}}, c_in};
            end
            CMD_AND: alu_res = src1 & op2;
            CMD_ORR: alu_res = src1 | op2;
            CMD_EOR: alu_res = src1 ^ op2;
            default: alu_res = '0;
        endcase
        if (is_arith) begin
            alu_res = sum_w[MSB:0];
            alu_c   = sum_w[DATA_W];
            if (is_sub)
                alu_v = (src1[MSB] != op2[MSB]) && (alu_res[MSB] != src1[MSB]);
            else
                alu_v = (src1[MSB] == op2[MSB]) && (alu_res[MSB] != src1[MSB]);
        end
    end

    assign alu_status = {alu_res[MSB], alu_res == '0, alu_c, alu_v};

    // Word offset sign-extended and scaled by 4; wide enough for any DATA_W
    assign br_off  = {{38{imm24[23]}}, imm24, 2'b00};
    assign br_calc = pc_in + br_off[MSB:0];

`ifdef EXE_MUL_EN
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam int CNT_W = $clog2(DATA_W);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] acc_reg, mcand_reg, mplier_reg;
    logic [DATA_W-1:0] hold_br_reg, hold_rm_reg;
    logic [REG_AW-1:0] hold_dest_reg;
    logic [2:0]        hold_flags_reg;
    logic              hold_c_reg;
    logic              is_mul, mul_last, done_load;

    assign is_mul    = (exe_cmd == CMD_MUL);
    assign mul_last  = (cnt_reg == CNT_W'(DATA_W - 1));
    assign in_ready  = (state_reg == S_IDLE) && out_free;
    assign done_load = (state_reg == S_DONE) && out_free;
    assign busy      = (state_reg != S_IDLE);
    assign load_out  = (accept && !is_mul) || done_load;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // FSM next state: one MUL cycle per multiplier bit, DONE waits for a free output slot
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept && is_mul) state_next = S_MUL;
            S_MUL:   if (mul_last) state_next = S_DONE;
            S_DONE:  if (out_free) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shift-add multiplier; side-band fields are captured at acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg        <= '0;
            acc_reg        <= '0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            hold_br_reg    <= '0;
            hold_rm_reg    <= '0;
            hold_dest_reg  <= '0;
            hold_flags_reg <= '0;
            hold_c_reg     <= 1'b0;
        end else if (accept && is_mul) begin
            cnt_reg        <= '0;
            acc_reg        <= '0;
            mcand_reg      <= src1;
            mplier_reg     <= op2;
            hold_br_reg    <= br_calc;
            hold_rm_reg    <= rm_fwd;
            hold_dest_reg  <= dest;
            hold_flags_reg <= {wb_en, mem_r_en, mem_w_en};
            hold_c_reg     <= c_in;
        end else if (state_reg == S_MUL) begin
            if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    // Output-register source: finished product or the single-cycle path
    always_comb begin
        ld_result = alu_res;
        ld_status = alu_status;
        ld_br     = br_calc;
        ld_rm     = rm_fwd;
        ld_dest   = dest;
        ld_flags  = {wb_en, mem_r_en, mem_w_en};
        if (done_load) begin
            ld_result = acc_reg;
            ld_status = {acc_reg[MSB], acc_reg == '0, hold_c_reg, 1'b0};
            ld_br     = hold_br_reg;
            ld_rm     = hold_rm_reg;
            ld_dest   = hold_dest_reg;
            ld_flags  = hold_flags_reg;
        end
    end
`else
    assign in_ready = out_free;
    assign busy     = 1'b0;
    assign load_out = accept;

    // Output-register source: every command completes in one cycle
    always_comb begin
        ld_result = alu_res;
        ld_status = alu_status;
        ld_br     = br_calc;
        ld_rm     = rm_fwd;
        ld_dest   = dest;
        ld_flags  = {wb_en, mem_r_en, mem_w_en};
    end
`endif

    // Output register: load new result, hold under backpressure, drain on out_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg  <= 1'b0;
            alu_result_reg <= '0;
            br_addr_reg    <= '0;
            val_rm_out_reg <= '0;
            status_reg     <= '0;
            dest_out_reg   <= '0;
            flags_out_reg  <= '0;
        end else if (load_out) begin
            out_valid_reg  <= 1'b1;
            alu_result_reg <= ld_result;
            br_addr_reg    <= ld_br;
            val_rm_out_reg <= ld_rm;
            status_reg     <= ld_status;
            dest_out_reg   <= ld_dest;
            flags_out_reg  <= ld_flags;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign alu_result   = alu_result_reg;
    assign br_addr      = br_addr_reg;
    assign val_rm_out   = val_rm_out_reg;
    assign status       = status_reg;
    assign dest_out     = dest_out_reg;
    assign wb_en_out    = flags_out_reg[2];
    assign mem_r_en_out = flags_out_reg[1];
    assign mem_w_en_out = flags_out_reg[0];
endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc (DATA_W=32): constant vector table,
// hand-written multi-cycle sequences and random traffic against an
// arithmetic reference model.
module tb_exe_stage_mc;
`ifdef EXE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  exe_cmd = '0;
    logic        wb_en = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [3:0]  dest = '0;
    logic [31:0] pc_in = '0, val_rn = '0, val_rm = '0, val2 = '0, mem_val = '0, wb_val = '0;
    logic [23:0] imm24 = '0;
    logic        op2_sel = 1'b0, c_in = 1'b0;
    logic [1:0]  sel_src1 = '0, sel_src2 = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] alu_result, br_addr, val_rm_out;
    logic [3:0]  status, dest_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_stage_mc #(.DATA_W(32), .REG_AW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .dest(dest), .pc_in(pc_in), .imm24(imm24), .val_rn(val_rn), .val_rm(val_rm),
        .val2(val2), .op2_sel(op2_sel), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_val(mem_val), .wb_val(wb_val), .c_in(c_in), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .br_addr(br_addr),
        .val_rm_out(val_rm_out), .status(status), .dest_out(dest_out),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .busy(busy)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] rn, rm, v2, mv, wv, pc;
        logic [23:0] imm;
        logic        osel, c;
        logic [1:0]  s1, s2;
        logic [3:0]  dst;
        logic [2:0]  fl;
    } req_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a, b;
        logic        c;
        logic [31:0] exp_r;
        logic [3:0]  exp_st;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit fits32(input longint x);
        return (x >= -(64'sd2147483648)) && (x <= 64'sd2147483647);
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] m, input logic [31:0] w);
        if (s == 2'b01) return m;
        if (s == 2'b10) return w;
        return r;
    endfunction

    // Reference ALU using 64-bit integer arithmetic and range tests for overflow
    function automatic void ref_exec(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, input logic c,
                                     output logic [31:0] r, output logic [3:0] st);
        longint unsigned ua, ub, uc, bw;
        longint sa, sb;
        logic cf, vf;
        ua = 64'(a); ub = 64'(b); uc = 64'(c); bw = 64'(!c);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        cf = c; vf = 1'b0; r = '0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010: begin r = 32'(ua + ub); cf = (ua + ub) > 64'hFFFF_FFFF; vf = !fits32(sa + sb); end
            4'b0011: begin r = 32'(ua + ub + uc); cf = (ua + ub + uc) > 64'hFFFF_FFFF;
                           vf = !fits32(sa + sb + longint'(uc)); end
            4'b0100: begin r = a - b; cf = ua >= ub; vf = !fits32(sa - sb); end
            4'b0101: begin r = a - b - 32'(bw); cf = ua >= ub + bw;
                           vf = !fits32(sa - sb - longint'(bw)); end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            4'b1010: r = MUL_EN ? 32'(ua * ub) : 32'd0;
            default: r = '0;
        endcase
        st = {r[31], r == 32'd0, cf, vf};
    endfunction

    function automatic req_t blank_req();
        req_t q;
        q.cmd = '0; q.rn = '0; q.rm = '0; q.v2 = '0; q.mv = '0; q.wv = '0; q.pc = '0;
        q.imm = '0; q.osel = 1'b1; q.c = 1'b0; q.s1 = '0; q.s2 = '0; q.dst = '0; q.fl = '0;
        return q;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic req_t rand_req();
        req_t q;
        q.cmd = 4'($urandom_range(0, 15));
`ifdef EXE_MUL_EN
        if (q.cmd == 4'b1010) q.cmd = 4'b0010;
`endif
        q.rn = pick(); q.rm = pick(); q.v2 = pick(); q.mv = pick(); q.wv = pick();
        q.pc = $urandom; q.imm = 24'($urandom);
        q.osel = 1'($urandom); q.c = 1'($urandom);
        q.s1 = 2'($urandom); q.s2 = 2'($urandom);
        q.dst = 4'($urandom); q.fl = 3'($urandom);
        return q;
    endfunction

    task automatic put(input req_t q);
        exe_cmd = q.cmd; val_rn = q.rn; val_rm = q.rm; val2 = q.v2; mem_val = q.mv;
        wb_val = q.wv; pc_in = q.pc; imm24 = q.imm; op2_sel = q.osel; c_in = q.c;
        sel_src1 = q.s1; sel_src2 = q.s2; dest = q.dst;
        {wb_en, mem_r_en, mem_w_en} = q.fl;
    endtask

    // Present a request, wait (bounded) for in_ready, return after the accepting edge
    task automatic issue(input req_t q, output int waited);
        waited = 0;
        put(q);
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Compare every registered output with the reference model for request q
    task automatic check_out(input req_t q, input string tag);
        logic [31:0] a, rmf, b, r, br;
        logic [3:0]  st;
        a   = fwd(q.s1, q.rn, q.mv, q.wv);
        rmf = fwd(q.s2, q.rm, q.mv, q.wv);
        b   = q.osel ? q.v2 : rmf;
        ref_exec(q.cmd, a, b, q.c, r, st);
        br = q.pc + 32'(longint'($signed(q.imm)) * 4);
        $display("txn %s cmd=%b a=%h b=%h c=%b -> res=%h st=%b br=%h", tag, q.cmd, a, b, q.c,
                 alu_result, status, br_addr);
        chk($sformatf("%s_valid", tag), out_valid, 1'b1);
        chk($sformatf("%s_result", tag), alu_result, r);
        chk($sformatf("%s_status", tag), status, st);
        chk($sformatf("%s_br", tag), br_addr, br);
        chk($sformatf("%s_rm", tag), val_rm_out, rmf);
        chk($sformatf("%s_dest", tag), dest_out, q.dst);
        chk($sformatf("%s_flags", tag), {wb_en_out, mem_r_en_out, mem_w_en_out}, q.fl);
    endtask

    task automatic check_zero(input string tag);
        chk($sformatf("%s_valid", tag), out_valid, 1'b0);
        chk($sformatf("%s_busy", tag), busy, 1'b0);
        chk($sformatf("%s_result", tag), alu_result, 32'd0);
        chk($sformatf("%s_br", tag), br_addr, 32'd0);
        chk($sformatf("%s_rm", tag), val_rm_out, 32'd0);
        chk($sformatf("%s_status", tag), status, 4'd0);
        chk($sformatf("%s_dest", tag), dest_out, 4'd0);
        chk($sformatf("%s_flags", tag), {wb_en_out, mem_r_en_out, mem_w_en_out}, 3'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[14];
        req_t q, q2;
        int   n, lat;
        bit   busy_ok;

        vt[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001};
        vt[1]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110};
        vt[2]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110};
        vt[3]  = '{4'b0011, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 4'b1001};
        vt[4]  = '{4'b0101, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0001, 4'b0010};
        vt[5]  = '{4'b0100, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1000};
        vt[6]  = '{4'b0100, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011};
        vt[7]  = '{4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'h00F0_00F0, 4'b0010};
        vt[8]  = '{4'b0111, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0100};
        vt[9]  = '{4'b1000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'hFFFF_FFFF, 4'b1000};
        vt[10] = '{4'b0001, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'b0010};
        vt[11] = '{4'b1001, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1000};
        vt[12] = '{4'b1111, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'h0000_0000, 4'b0110};
        vt[13] = '{4'b0000, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0000_0000, 4'b0100};

        // Reset state and first-cycle readiness
        #3;
        check_zero("reset");
        #11 rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1'b1);

        // Constant vector table
        foreach (vt[i]) begin
            q = blank_req();
            q.cmd = vt[i].cmd; q.rn = vt[i].a; q.v2 = vt[i].b; q.c = vt[i].c;
            q.rm = $urandom; q.dst = 4'(i);
            issue(q, n);
            $display("txn vec%0d cmd=%b a=%h b=%h c=%b -> res=%h st=%b", i, vt[i].cmd,
                     vt[i].a, vt[i].b, vt[i].c, alu_result, status);
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_result", i), alu_result, vt[i].exp_r);
            chk($sformatf("vec%0d_status", i), status, vt[i].exp_st);
        end

        // Forwarded SUB: Rn from mem_val, Rm from wb_val
        q = blank_req();
        q.cmd = 4'b0100; q.rn = 32'd99; q.s1 = 2'b01; q.mv = 32'd5; q.v2 = 32'd5;
        q.s2 = 2'b10; q.wv = 32'h0000_ABCD; q.rm = 32'd1;
        issue(q, n);
        $display("txn fwd_sub res=%h st=%b rm_out=%h", alu_result, status, val_rm_out);
        chk("fwd_sub_result", alu_result, 32'd0);
        chk("fwd_sub_status", status, 4'b0110);
        chk("fwd_sub_rm_out", val_rm_out, 32'h0000_ABCD);

        // Forwarded Rm as operand 2 (op2_sel=0)
        q = blank_req();
        q.cmd = 4'b0010; q.rn = 32'd1; q.osel = 1'b0; q.v2 = 32'hDEAD; q.s2 = 2'b01; q.mv = 32'h10;
        issue(q, n);
        $display("txn fwd_rm_add res=%h", alu_result);
        chk("fwd_rm_add_result", alu_result, 32'h11);

        // Branch address arithmetic
        q = blank_req();
        q.cmd = 4'b0001; q.pc = 32'h100; q.imm = 24'hFFFFFF;
        issue(q, n);
        $display("txn br_neg br=%h", br_addr);
        chk("br_neg", br_addr, 32'h0FC);
        q.imm = 24'h000001;
        issue(q, n);
        $display("txn br_pos br=%h", br_addr);
        chk("br_pos", br_addr, 32'h104);
        q.pc = 32'h0; q.imm = 24'h800000;
        issue(q, n);
        $display("txn br_min br=%h", br_addr);
        chk("br_min", br_addr, 32'hFE00_0000);

        // Backpressure: output holds, second request stalls until out_ready
        @(posedge clk); #1;
        out_ready = 1'b0;
        q = blank_req();
        q.cmd = 4'b0010; q.rn = 32'd1; q.v2 = 32'd2; q.dst = 4'd3;
        issue(q, n);
        $display("txn bp_first res=%h", alu_result);
        chk("bp_first", alu_result, 32'd3);
        q2 = blank_req();
        q2.cmd = 4'b0010; q2.rn = 32'd10; q2.v2 = 32'd20; q2.dst = 4'd4;
        put(q2);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold_result", alu_result, 32'd3);
            chk("bp_hold_dest", dest_out, 4'd3);
            chk("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("txn bp_second res=%h", alu_result);
        chk("bp_second", alu_result, 32'd30);
        chk("bp_second_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("bp_drain", out_valid, 1'b0);

`ifdef EXE_MUL_EN
        // Multi-cycle multiply: busy until result, latency 33
        q = blank_req();
        q.cmd = 4'b1010; q.rn = 32'h1234; q.v2 = 32'h10; q.dst = 4'd7;
        issue(q, n);
        lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        $display("txn mul res=%h lat=%0d", alu_result, lat);
        chk("mul_latency", lat, 33);
        chk("mul_busy_held", busy_ok, 1'b1);
        chk("mul_result", alu_result, 32'h12340);
        chk("mul_status", status, 4'b0000);
        chk("mul_dest", dest_out, 4'd7);
        chk("mul_busy_after", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            q = rand_req();
            q.cmd = 4'b1010;
            issue(q, n);
            lat = 0;
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("rmul%0d_latency", k), lat, 33);
            check_out(q, $sformatf("rmul%0d", k));
        end
`else
        // Without the multiplier, 1010 is an undefined single-cycle command
        q = blank_req();
        q.cmd = 4'b1010; q.rn = 32'h1234; q.v2 = 32'h10; q.c = 1'b1;
        issue(q, n);
        $display("txn mul_undef res=%h st=%b", alu_result, status);
        chk("mul_undef_valid", out_valid, 1'b1);
        chk("mul_undef_result", alu_result, 32'd0);
        chk("mul_undef_status", status, 4'b0110);
        chk("mul_undef_busy", busy, 1'b0);
`endif

        // Asynchronous reset with non-zero outputs (mid-multiply when present)
        q = blank_req();
        q.cmd = 4'b0010; q.rn = 32'h11; q.v2 = 32'h22; q.dst = 4'd5; q.fl = 3'b111;
        q.pc = 32'h40; q.imm = 24'h1; q.rm = 32'h55;
        issue(q, n);
        chk("pre_rst_result", alu_result, 32'h33);
`ifdef EXE_MUL_EN
        q = blank_req();
        q.cmd = 4'b1010; q.rn = 32'd3; q.v2 = 32'd7;
        issue(q, n);
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_busy", busy, 1'b1);
`endif
        #2 rst = 1'b0;
        #1;
        $display("txn async_reset");
        check_zero("rst_async");
        @(posedge clk); #1;
        check_zero("rst_hold");
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", in_ready, 1'b1);
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) lat++;
        end
        chk("rst_discarded", lat, 0);

        // Random back-to-back traffic, one result per cycle
        for (int i = 0; i < 150; i++) begin
            q = rand_req();
            issue(q, n);
            chk($sformatf("rnd%0d_nowait", i), n, 0);
            check_out(q, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
